// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache: 32 lines of 256 bits.
// A single FSM writes back dirty victims and refills lines; the CPU pipeline stays stalled until its request hits.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    input  logic         p1_MemRead_i,
    input  logic         p1_MemWrite_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_REFILL_DONE
    } state_t;

    state_t state_q, state_d;

    logic         valid_q [32];
    logic         dirty_q [32];
    logic [21:0]  tag_q   [32];
    logic [255:0] data_q  [32];

    logic [21:0]  req_tag;
    logic [4:0]   req_idx;
    logic [2:0]   req_word;
    logic [7:0]   word_lsb;
    logic         unused_addr_bits;

    logic         req;
    logic         is_load;
    logic         hit;
    logic         victim_dirty;
    logic         store_hit;
    logic         refill_we;

    assign req_tag          = p1_addr_i[31:10];
    assign req_idx          = p1_addr_i[9:5];
    assign req_word         = p1_addr_i[4:2];
    assign word_lsb         = {req_word, 5'b0};
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // A request with both strobes high is handled as a store.
    assign req          = p1_MemRead_i | p1_MemWrite_i;
    assign is_load      = p1_MemRead_i & ~p1_MemWrite_i;
    assign hit          = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];
    assign store_hit    = (state_q == S_IDLE) & p1_MemWrite_i & hit;
    assign refill_we    = (state_q == S_REFILL) & mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        p1_stall_o   = 1'b1;
        p1_data_o    = '0;
        case (state_q)
            S_IDLE: begin
                p1_stall_o = req & ~hit;
                if (is_load && hit) begin
                    p1_data_o = data_q[req_idx][word_lsb +: 32];
                end
                if (req && !hit) begin
                    state_d = victim_dirty ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[req_idx], req_idx, 5'b0};
                mem_data_o   = data_q[req_idx];
                if (mem_ack_i) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, req_idx, 5'b0};
                if (mem_ack_i) begin
                    state_d = S_REFILL_DONE;
                end
            end
            S_REFILL_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < 32; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else if (refill_we) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; a cleared valid bit masks their contents.
    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_data_i;
        end else if (store_hit) begin
            data_q[req_idx][word_lsb +: 32] <= p1_data_i;
        end
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have no parameters: 32 lines, 256-bit lines, direct-mapped, write-back, write-allocate.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 p1_addr_i  in  32  CPU byte address; tag=[31:10], index=[9:5], word=[4:2], [1:0] ignored.
REQ-005 p1_data_i  in  32  CPU store data.
REQ-006 p1_MemRead_i  in  1  load request.
REQ-007 p1_MemWrite_i  in  1  store request.
REQ-008 p1_data_o  out  32  load data; feeds the MEM/WB buffer.
REQ-009 p1_stall_o  out  1  pipeline-wide stall (drives all_stall_i of every pipeline buffer).
REQ-010 mem_addr_o  out  32  line-aligned memory address, bits [4:0]=0.
REQ-011 mem_data_o  out  256  victim line for writeback.
REQ-012 mem_enable_o  out  1  memory request valid.
REQ-013 mem_write_o  out  1  1=write, 0=read.
REQ-014 mem_data_i  in  256  refill line.
REQ-015 mem_ack_i  in  1  one-cycle completion pulse from memory.

Function
REQ-016 Request = MemRead|MemWrite; both high SHALL be treated as a store.
REQ-017 Hit = valid[index] & (tag_array[index]==addr[31:10]), combinational.
REQ-018 Load hit: p1_data_o = selected word of line, same cycle, p1_stall_o=0.
REQ-019 Store hit: word written and dirty[index] set at next posedge; p1_stall_o=0.
REQ-020 Miss (request & ~hit) in IDLE: p1_stall_o=1 combinationally that cycle; stall SHALL stay 1 until the request hits.
REQ-021 FSM states: IDLE, WRITEBACK, REFILL, REFILL_DONE; encoding free.
REQ-022 IDLE -> WRITEBACK on miss with dirty victim; IDLE -> REFILL on miss with clean or invalid victim.
REQ-023 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line, all held stable; -> REFILL on mem_ack_i.
REQ-024 REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}; on mem_ack_i line written with mem_data_i, valid=1, dirty=0, tag updated; -> REFILL_DONE.
REQ-025 REFILL_DONE: mem_enable_o=0, stall held 1; -> IDLE unconditionally; request then hits and completes per REQ-018/019.
REQ-026 Miss latency from miss cycle: clean = ack delay + 2 cycles; dirty = two ack delays + 2 cycles.
REQ-027 mem_enable_o SHALL be 0 in IDLE and REFILL_DONE; mem_ack_i outside WRITEBACK/REFILL ignored.
REQ-028 p1_data_o SHALL be 0 when no load request; p1_stall_o=0 when no request.
REQ-029 Address/data/controls from CPU SHALL be held by the stalled pipeline; block does not latch them.
REQ-030 Index wrap: index 31 and index 0 independent; no cross-line effects.

Reset
REQ-031 rst_i=0 SHALL immediately force state=IDLE, all valid=0, all dirty=0, mem_enable_o=0, mem_write_o=0, p1_stall_o follows REQ-020 (miss => 1 once reset releases).
REQ-032 Reset during WRITEBACK/REFILL SHALL abort the transaction; a late mem_ack_i after release is ignored.
REQ-033 Data and tag arrays need not be cleared; valid=0 guarantees no false hit.

Verification
REQ-034 After reset, load 0x0000_0404 -> stall=1, REFILL addr 0x0000_0400, ack with line word1=0xDEAD_BEEF -> after REFILL_DONE stall=0, p1_data_o=0xDEAD_BEEF.
REQ-035 Store 0x1234_5678 to 0x0000_0408 (line resident) -> no stall; later load 0x0000_0408 returns 0x1234_5678.
REQ-036 Load 0x0000_0808 (same index 0, dirty victim) -> WRITEBACK addr 0x0000_0400, mem_data_o word2=0x1234_5678, then REFILL addr 0x0000_0800.
REQ-037 Ack delayed 10 cycles -> mem_enable_o, mem_addr_o, mem_write_o stable for all 10; stall=1 throughout.
REQ-038 rst_i pulsed low mid-REFILL -> mem_enable_o=0 immediately; subsequent load to same address misses again.
REQ-039 Load 0x0000_03E0 (index 31) then 0x0000_0000 (index 0) -> two independent refills, both later hit.
